axis_opt_sc_fifo: RTL

Single-clock, parametrised AXI-Stream buffer; the same-clock successor of the optional CC FIFO family. It provides selectable depth, including a zero-depth pass-through. It adds an optional TLAST packet mode, a fill-level output and a programmable almost-full flag. It sits between DSP/streaming stages that share one clock and need elastic buffering, burst absorption or whole-packet release.

---
 rtl/axis_opt_sc_fifo_pkg.sv | 22 ++
 rtl/axis_opt_fifo_ram.sv | 24 ++
 rtl/axis_opt_sc_fifo.sv | 110 +++++++++++
 3 files changed

// File: rtl/axis_opt_sc_fifo_pkg.sv
// Shared helpers for the single-clock optional AXI-Stream FIFO: sizing math
// and the depth legality rule checked at elaboration.
package axis_opt_sc_fifo_pkg;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'(1) << i) < 64'(value)) result = i + 1;
        end
        return result;
    endfunction

    // Width of the level / packet counters; a zero-depth FIFO keeps a 1-bit port.
    function automatic int unsigned level_width(input int unsigned deep);
        return (deep == 0) ? 1 : clog2(deep + 1);
    endfunction

    function automatic bit deep_is_legal(input int unsigned deep);
        return (deep == 0) || (deep >= 2 && deep <= 1024 && (deep & (deep - 1)) == 0);
    endfunction

endpackage

// File: rtl/axis_opt_fifo_ram.sv
// Simple dual-port distributed RAM: synchronous write, asynchronous read.
module axis_opt_fifo_ram
    import axis_opt_sc_fifo_pkg::*;
#(
    parameter int unsigned DW   = 13,
    parameter int unsigned DEEP = 32
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [clog2(DEEP)-1:0]   wr_addr,
    input  logic [DW-1:0]            wr_data,
    input  logic [clog2(DEEP)-1:0]   rd_addr,
    output logic [DW-1:0]            rd_data
);

    logic [DW-1:0] mem [DEEP];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/axis_opt_sc_fifo.sv
// Single-clock AXI-Stream FIFO with optional zero-depth pass-through, token-only
// storage, whole-packet release, fill level and almost-full flag.
module axis_opt_sc_fifo
    import axis_opt_sc_fifo_pkg::*;
#(
    parameter int unsigned WIDTH       = 12,
    parameter bit          NO_DATA     = 1'b0,
    parameter int unsigned DEEP        = 32,
    parameter bit          PACKET_MODE = 1'b0,
    parameter int unsigned AF_THRESH   = DEEP - 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [WIDTH-1:0]              s_rx_tdata,
    input  logic                          s_rx_tlast,
    input  logic                          s_rx_tvalid,
    output logic                          s_rx_tready,
    output logic [WIDTH-1:0]              m_tx_tdata,
    output logic                          m_tx_tlast,
    output logic                          m_tx_tvalid,
    input  logic                          m_tx_tready,
    output logic [level_width(DEEP)-1:0]  level,
    output logic                          almost_full,
    output logic [level_width(DEEP)-1:0]  pkt_count
);

    localparam int unsigned LW = level_width(DEEP);

    if (!deep_is_legal(DEEP)) begin : g_bad_deep
        $error("axis_opt_sc_fifo: DEEP=%0d must be 0 or a power of two in 2..1024", DEEP);
    end

    if (DEEP == 0) begin : g_pass
        assign m_tx_tdata  = NO_DATA ? '0 : s_rx_tdata;
        assign m_tx_tlast  = s_rx_tlast;
        assign m_tx_tvalid = s_rx_tvalid;
        assign s_rx_tready = m_tx_tready;
        assign level       = '0;
        assign pkt_count   = '0;
        assign almost_full = 1'b0;
    end else begin : g_fifo
        localparam int unsigned AW = clog2(DEEP);
        localparam int unsigned PW = AW + 1;
        localparam int unsigned RW = NO_DATA ? 1 : WIDTH + 1;

        logic [PW-1:0] wr_ptr, rd_ptr;
        logic [LW-1:0] level_nxt, pkt_nxt;
        logic [RW-1:0] wr_word, rd_word;
        logic          full, empty, wr_en, rd_en;

        // Pointer MSB differs only once the writer has lapped the reader.
        assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        assign empty = (wr_ptr == rd_ptr);

        assign s_rx_tready = !full && !rst;
        assign m_tx_tvalid = !empty && (!PACKET_MODE || (pkt_count != '0) || full);
        assign wr_en       = s_rx_tvalid && s_rx_tready;
        assign rd_en       = m_tx_tvalid && m_tx_tready;

        if (NO_DATA) begin : g_token
            assign wr_word    = s_rx_tlast;
            assign m_tx_tdata = '0;
        end else begin : g_data
            assign wr_word    = {s_rx_tdata, s_rx_tlast};
            assign m_tx_tdata = rd_word[RW-1:1];
        end
        assign m_tx_tlast = rd_word[0];

        axis_opt_fifo_ram #(
            .DW   (RW),
            .DEEP (DEEP)
        ) u_ram (
            .clk     (clk),
            .wr_en   (wr_en),
            .wr_addr (wr_ptr[AW-1:0]),
            .wr_data (wr_word),
            .rd_addr (rd_ptr[AW-1:0]),
            .rd_data (rd_word)
        );

        always_comb begin
            level_nxt = level;
            pkt_nxt   = pkt_count;
            if (wr_en && !rd_en) level_nxt = level + LW'(1);
            else if (rd_en && !wr_en) level_nxt = level - LW'(1);
            case ({wr_en && s_rx_tlast, rd_en && m_tx_tlast})
                2'b10:   pkt_nxt = pkt_count + LW'(1);
                2'b01:   pkt_nxt = pkt_count - LW'(1);
                default: pkt_nxt = pkt_count;
            endcase
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                wr_ptr      <= '0;
                rd_ptr      <= '0;
                level       <= '0;
                pkt_count   <= '0;
                almost_full <= (AF_THRESH == 0);
            end else begin
                if (wr_en) wr_ptr <= wr_ptr + PW'(1);
                if (rd_en) rd_ptr <= rd_ptr + PW'(1);
                level       <= level_nxt;
                pkt_count   <= pkt_nxt;
                almost_full <= (32'(level_nxt) >= AF_THRESH);
            end
        end
    end

endmodule
